// File: rtl/spi_master_mc.sv
// SPI master with runtime transfer length, CPOL/CPHA modes, one-hot active-low chip selects and a runtime divider.
// Define SPI_3WIRE_EN to add half-duplex 3-wire support (spi3w/nwr ports, bidirectional spi_sdi).
module spi_master_mc #(
  parameter int          DATA_W  = 32,
  parameter int          NCS     = 4,
  parameter int          DIV_W   = 16,
  parameter int unsigned DIV_RST = 10000,
  localparam int         NB_W    = $clog2(DATA_W + 1),
  localparam int         CS_W    = (NCS > 1) ? $clog2(NCS) : 1
) (
  input  logic              clk_in,
  input  logic              nrst,
  input  logic              div_wr,
  input  logic [DIV_W-1:0]  div_val,
  input  logic              request,
  input  logic [NB_W-1:0]   nbits,
  input  logic [CS_W-1:0]   cs_sel,
  input  logic              cpol,
  input  logic              cpha,
  input  logic [DATA_W-1:0] mosi_data,
  output logic [DATA_W-1:0] miso_data,
  output logic              busy,
  output logic              done,
  output logic [NCS-1:0]    spi_cen,
  output logic              spi_scl,
  input  logic              spi_sdo,
`ifdef SPI_3WIRE_EN
  input  logic              spi3w,
  input  logic [NB_W-1:0]   nwr,
  inout  wire               spi_sdi
`else
  output logic              spi_sdi
`endif
);

  // Handshake: request is accepted on a rising edge where busy=0 and 1<=nbits<=DATA_W;
  // busy stays high until the edge that raises done for exactly one cycle.
  typedef enum logic [1:0] {IDLE, SETUP, EDGE, GAP} state_t;

  localparam logic [NB_W:0] ECNT_ONE = (NB_W + 1)'(1);

  state_t            state_q, state_d;
  logic [DIV_W-1:0]  div_q, div_cnt;
  logic [NB_W:0]     ecnt, ecnt_nx;
  logic [NB_W-1:0]   nbits_q;
  logic              cpol_q, cpha_q;
  logic [DATA_W-1:0] tx_sr, tx_aligned;
  logic [NCS-1:0]    cen_sel;
  logic              sdi_q, sample_in;
  logic              accept, phase_end, last_edge, edge_start, gap_start;
  logic              sample_pt, drive_pt;

  assign accept     = request && (state_q == IDLE) && (nbits != '0) && (nbits <= NB_W'(DATA_W));
  assign busy       = (state_q != IDLE);
  assign phase_end  = (div_cnt == div_q);
  assign last_edge  = (state_q == EDGE) && (ecnt == ECNT_ONE);
  assign edge_start = phase_end && ((state_q == SETUP) || ((state_q == EDGE) && !last_edge));
  assign gap_start  = phase_end && last_edge;
  assign ecnt_nx    = (state_q == SETUP) ? {nbits_q, 1'b0} : ecnt - 1'b1;
  // E index is odd exactly when the remaining-edge count is even.
  assign sample_pt  = edge_start && (ecnt_nx[0] == cpha_q);
  assign drive_pt   = edge_start && (ecnt_nx[0] != cpha_q) && (ecnt_nx != ECNT_ONE);
  // Left-align the tx word so the next bit to send is always at the MSB.
  assign tx_aligned = mosi_data << (NB_W'(DATA_W) - nbits);

  always_comb begin
    cen_sel = '1;
    for (int i = 0; i < NCS; i++) begin
      if (cs_sel == CS_W'(i)) cen_sel[i] = 1'b0;
    end
  end

  always_ff @(posedge clk_in or negedge nrst) begin
    if (!nrst) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept)    state_d = SETUP;
      SETUP:   if (phase_end) state_d = EDGE;
      EDGE:    if (gap_start) state_d = GAP;
      GAP:     if (phase_end) state_d = IDLE;
      default:                state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_in or negedge nrst) begin
    if (!nrst) begin
      div_q     <= DIV_W'(DIV_RST);
      div_cnt   <= '0;
      ecnt      <= '0;
      nbits_q   <= '0;
      cpol_q    <= 1'b1;
      cpha_q    <= 1'b0;
      tx_sr     <= '0;
      miso_data <= '0;
      done      <= 1'b0;
      spi_cen   <= '1;
      spi_scl   <= 1'b1;
      sdi_q     <= 1'b1;
    end else begin
      done <= 1'b0;
      if (div_wr && !busy) div_q <= div_val;
      if (accept) begin
        nbits_q   <= nbits;
        cpol_q    <= cpol;
        cpha_q    <= cpha;
        miso_data <= '0;
        spi_cen   <= cen_sel;
        spi_scl   <= cpol;
        div_cnt   <= '0;
        if (!cpha) begin
          sdi_q <= tx_aligned[DATA_W-1];
          tx_sr <= tx_aligned << 1;
        end else begin
          tx_sr <= tx_aligned;
        end
      end else if (busy) begin
        div_cnt <= phase_end ? '0 : div_cnt + 1'b1;
        if (edge_start) begin
          ecnt    <= ecnt_nx;
          spi_scl <= ~spi_scl;
        end
        if (drive_pt) begin
          sdi_q <= tx_sr[DATA_W-1];
          tx_sr <= tx_sr << 1;
        end
        if (sample_pt) miso_data <= {miso_data[DATA_W-2:0], sample_in};
        if (gap_start) begin
          spi_cen <= '1;
          sdi_q   <= 1'b1;
          spi_scl <= cpol_q;
        end
        if ((state_q == GAP) && phase_end) done <= 1'b1;
      end
    end
  end

`ifdef SPI_3WIRE_EN
  logic            spi3w_q, oe_q;
  logic [NB_W-1:0] nwr_q, drv_cnt;

  // drv_cnt is the index of the next bit to be driven; once it reaches nwr the line is released.
  always_ff @(posedge clk_in or negedge nrst) begin
    if (!nrst) begin
      spi3w_q <= 1'b0;
      nwr_q   <= '0;
      drv_cnt <= '0;
      oe_q    <= 1'b1;
    end else if (accept) begin
      spi3w_q <= spi3w;
      nwr_q   <= nwr;
      oe_q    <= 1'b1;
      if (!cpha) begin
        drv_cnt <= NB_W'(1);
        if (spi3w && (nwr == '0)) oe_q <= 1'b0;
      end else begin
        drv_cnt <= '0;
      end
    end else if (drive_pt) begin
      drv_cnt <= drv_cnt + 1'b1;
      if (spi3w_q && (drv_cnt >= nwr_q)) oe_q <= 1'b0;
    end else if (gap_start) begin
      oe_q <= 1'b1;
    end
  end

  assign sample_in = spi3w_q ? spi_sdi : spi_sdo;
  assign spi_sdi   = oe_q ? sdi_q : 1'bz;
`else
  assign sample_in = spi_sdo;
  assign spi_sdi   = sdi_q;
`endif

endmodule

// File: tb/tb_spi_master_mc.sv
// Directed bench for spi_master_mc: loopback and mode-aware slave model, divider, framing and reset checks.
module tb_spi_master_mc;

  logic        clk_in = 1'b0;
  logic        nrst;
  logic        div_wr;
  logic [15:0] div_val;
  logic        request;
  logic [5:0]  nbits;
  logic [1:0]  cs_sel;
  logic        cpol, cpha;
  logic [31:0] mosi_data, miso_data;
  logic        busy, done;
  logic [3:0]  spi_cen;
  logic        spi_scl, spi_sdo;
`ifdef SPI_3WIRE_EN
  logic        spi3w;
  logic [5:0]  nwr;
  wire         spi_sdi;
  logic        slv3_en = 1'b0;
  logic        slv_drv3 = 1'b0;
`else
  logic        spi_sdi;
`endif

  int checks = 0;
  int errors = 0;

  logic        slv_loop = 1'b1;
  logic        slv_cpha = 1'b0;
  int          slv_n = 8;
  logic [31:0] slv_tx = '0;
  logic [31:0] slv_rx = '0;
  logic        slv_sdo = 1'b0;
  logic        cs_prev = 1'b0;
  logic        scl_prev = 1'b1;
  logic        cs_act;
  int          slv_edge, slv_idx;

  int          res_done_off, res_low, res_tog, res_t1, res_t2;
  logic        res_scl0, res_scl_end, res_busy;
  logic [3:0]  res_cen0;
  logic [31:0] res_miso;

  always #5 clk_in = ~clk_in;

  assign spi_sdo = slv_loop ? spi_sdi : slv_sdo;
`ifdef SPI_3WIRE_EN
  assign spi_sdi = slv_drv3 ? slv_sdo : 1'bz;
`endif

  spi_master_mc #(.DATA_W(32), .NCS(4), .DIV_W(16), .DIV_RST(5)) dut (
    .clk_in(clk_in), .nrst(nrst), .div_wr(div_wr), .div_val(div_val),
    .request(request), .nbits(nbits), .cs_sel(cs_sel), .cpol(cpol), .cpha(cpha),
    .mosi_data(mosi_data), .miso_data(miso_data), .busy(busy), .done(done),
    .spi_cen(spi_cen), .spi_scl(spi_scl), .spi_sdo(spi_sdo),
`ifdef SPI_3WIRE_EN
    .spi3w(spi3w), .nwr(nwr),
`endif
    .spi_sdi(spi_sdi));

  // Slave model: drives on the non-sample edge, captures the master output on the sample edge.
  always @(posedge clk_in) begin
    #1;
    cs_act = (spi_cen != 4'hF);
    if (cs_act && !cs_prev) begin
      slv_edge = 0;
      slv_idx  = slv_n - 1;
      slv_sdo  = slv_tx[slv_idx];
      slv_rx   = '0;
    end else if (cs_act && (spi_scl !== scl_prev)) begin
      slv_edge++;
      if (slv_edge[0] != slv_cpha) slv_rx = {slv_rx[30:0], spi_sdi};
      else if (!slv_cpha) begin
        if (slv_idx > 0) begin
          slv_idx--;
          slv_sdo = slv_tx[slv_idx];
`ifdef SPI_3WIRE_EN
          if (slv3_en && slv_idx < 8) slv_drv3 = 1'b1;
`endif
        end
      end else begin
        slv_sdo = slv_tx[slv_idx];
        if (slv_idx > 0) slv_idx--;
      end
    end
`ifdef SPI_3WIRE_EN
    if (!cs_act) slv_drv3 = 1'b0;
`endif
    cs_prev  = cs_act;
    scl_prev = spi_scl;
  end

  task automatic run_xfer(input logic [5:0] nb, input logic [1:0] cs, input logic pol, input logic pha,
                          input logic [31:0] mosi, input logic wr_now, input logic wr_mid,
                          input logic [15:0] dv, input int budget);
    logic prev;
    @(negedge clk_in);
    request = 1'b1; nbits = nb; cs_sel = cs; cpol = pol; cpha = pha; mosi_data = mosi;
    div_wr = wr_now; div_val = dv; slv_cpha = pha; slv_n = int'(nb);
    @(negedge clk_in);
    request = 1'b0; div_wr = 1'b0;
    nbits = 6'($urandom_range(0, 63)); cs_sel = 2'($urandom_range(0, 3));
    cpol = 1'($urandom_range(0, 1)); cpha = 1'($urandom_range(0, 1)); mosi_data = $urandom;
    res_done_off = -1; res_low = 0; res_tog = 0; res_t1 = -1; res_t2 = -1;
    res_scl0 = spi_scl; res_cen0 = spi_cen; prev = spi_scl;
    res_miso = 'x; res_busy = 1'bx; res_scl_end = 1'bx;
    for (int off = 0; off < budget; off++) begin
      if (off > 0) @(negedge clk_in);
      if (wr_mid && off == 2) begin div_wr = 1'b1; div_val = 16'd3; end
      else div_wr = 1'b0;
      if (spi_cen != 4'hF) res_low++;
      if (spi_scl !== prev) begin
        if (res_tog == 0) res_t1 = off;
        else if (res_tog == 1) res_t2 = off;
        res_tog++;
      end
      prev = spi_scl;
      if (done === 1'b1) begin
        res_done_off = off; res_miso = miso_data; res_busy = busy; res_scl_end = spi_scl;
        break;
      end
    end
    div_wr = 1'b0;
  endtask

  task automatic test_reset;
    nrst = 1'b0;
    repeat (2) @(negedge clk_in);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %b exp 0", done); end
    checks++; if (miso_data !== 32'h0) begin errors++; $display("FAIL reset_miso got %h exp 0", miso_data); end
    checks++; if (spi_cen !== 4'hF) begin errors++; $display("FAIL reset_cen got %b exp 1111", spi_cen); end
    checks++; if (spi_scl !== 1'b1) begin errors++; $display("FAIL reset_scl got %b exp 1", spi_scl); end
    checks++; if (spi_sdi !== 1'b1) begin errors++; $display("FAIL reset_sdi got %b exp 1", spi_sdi); end
    nrst = 1'b1;
    @(negedge clk_in);
  endtask

  task automatic test_div_reset;
    run_xfer(6'd2, 2'd0, 1'b0, 1'b0, 32'h2, 1'b0, 1'b0, 16'd0, 200);
    checks++; if (res_done_off !== 36) begin errors++; $display("FAIL divrst_done got %0d exp 36", res_done_off); end
    checks++; if (res_low !== 30) begin errors++; $display("FAIL divrst_cs_low got %0d exp 30", res_low); end
    checks++; if (res_t2 - res_t1 !== 6) begin errors++; $display("FAIL divrst_half got %0d exp 6", res_t2 - res_t1); end
    checks++; if (res_miso !== 32'h2) begin errors++; $display("FAIL divrst_miso got %h exp 2", res_miso); end
  endtask

  task automatic test_mode0;
    @(negedge clk_in); div_wr = 1'b1; div_val = 16'd0;
    @(negedge clk_in); div_wr = 1'b0;
    run_xfer(6'd8, 2'd2, 1'b0, 1'b0, 32'hA5, 1'b0, 1'b0, 16'd0, 100);
    checks++; if (res_cen0 !== 4'b1011) begin errors++; $display("FAIL m0_cen got %b exp 1011", res_cen0); end
    checks++; if (res_low !== 17) begin errors++; $display("FAIL m0_cs_low got %0d exp 17", res_low); end
    checks++; if (res_done_off !== 18) begin errors++; $display("FAIL m0_done got %0d exp 18", res_done_off); end
    checks++; if (res_miso !== 32'hA5) begin errors++; $display("FAIL m0_miso got %h exp a5", res_miso); end
    checks++; if (res_scl0 !== 1'b0) begin errors++; $display("FAIL m0_scl_idle got %b exp 0", res_scl0); end
    checks++; if (res_tog !== 16) begin errors++; $display("FAIL m0_edges got %0d exp 16", res_tog); end
    checks++; if (res_busy !== 1'b0) begin errors++; $display("FAIL m0_busy_at_done got %b exp 0", res_busy); end
    @(negedge clk_in);
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL m0_done_width got %b exp 0", done); end
  endtask

  task automatic test_modes;
    logic [1:0] mm;
    for (int m = 1; m < 4; m++) begin
      mm = 2'(m);
      slv_loop = 1'b1;
      run_xfer(6'd32, 2'd1, mm[1], mm[0], 32'hDEADBEEF, 1'b0, 1'b0, 16'd0, 200);
      checks++; if (res_miso !== 32'hDEADBEEF) begin errors++; $display("FAIL mode%0d_loop_miso got %h exp deadbeef", m, res_miso); end
      checks++; if (res_done_off !== 66) begin errors++; $display("FAIL mode%0d_done got %0d exp 66", m, res_done_off); end
      checks++; if (res_scl0 !== mm[1]) begin errors++; $display("FAIL mode%0d_scl_start got %b exp %b", m, res_scl0, mm[1]); end
      checks++; if (res_scl_end !== mm[1]) begin errors++; $display("FAIL mode%0d_scl_end got %b exp %b", m, res_scl_end, mm[1]); end
      checks++; if (res_tog !== 64) begin errors++; $display("FAIL mode%0d_edges got %0d exp 64", m, res_tog); end
    end
    for (int m = 0; m < 4; m++) begin
      mm = 2'(m);
      slv_loop = 1'b0; slv_tx = 32'h1234_5678;
      run_xfer(6'd32, 2'd0, mm[1], mm[0], 32'hDEADBEEF, 1'b0, 1'b0, 16'd0, 200);
      checks++; if (res_miso !== 32'h1234_5678) begin errors++; $display("FAIL mode%0d_slave_miso got %h exp 12345678", m, res_miso); end
      checks++; if (slv_rx !== 32'hDEADBEEF) begin errors++; $display("FAIL mode%0d_slave_rx got %h exp deadbeef", m, slv_rx); end
    end
    slv_loop = 1'b1;
  endtask

  task automatic test_div_write;
    run_xfer(6'd4, 2'd1, 1'b0, 1'b0, 32'h9, 1'b0, 1'b1, 16'd0, 100);
    checks++; if (res_done_off !== 10) begin errors++; $display("FAIL divbusy_done got %0d exp 10", res_done_off); end
    @(negedge clk_in); div_wr = 1'b1; div_val = 16'd3;
    @(negedge clk_in); div_wr = 1'b0;
    run_xfer(6'd4, 2'd1, 1'b0, 1'b0, 32'h6, 1'b0, 1'b0, 16'd0, 200);
    checks++; if (res_t2 - res_t1 !== 4) begin errors++; $display("FAIL div3_half got %0d exp 4", res_t2 - res_t1); end
    checks++; if (res_low !== 36) begin errors++; $display("FAIL div3_cs_low got %0d exp 36", res_low); end
    checks++; if (res_done_off !== 40) begin errors++; $display("FAIL div3_done got %0d exp 40", res_done_off); end
    checks++; if (res_miso !== 32'h6) begin errors++; $display("FAIL div3_miso got %h exp 6", res_miso); end
  endtask

  task automatic test_back_to_back;
    run_xfer(6'd2, 2'd3, 1'b1, 1'b1, 32'hFFFF_FFF9, 1'b1, 1'b0, 16'd1, 100);
    checks++; if (res_cen0 !== 4'b0111) begin errors++; $display("FAIL b2b_cen got %b exp 0111", res_cen0); end
    checks++; if (res_done_off !== 12) begin errors++; $display("FAIL b2b_done got %0d exp 12", res_done_off); end
    checks++; if (res_low !== 10) begin errors++; $display("FAIL b2b_cs_low got %0d exp 10", res_low); end
    checks++; if (res_miso !== 32'h1) begin errors++; $display("FAIL b2b_miso got %h exp 1", res_miso); end
  endtask

  task automatic test_bad_nbits;
    int dones = 0;
    @(negedge clk_in); request = 1'b1; nbits = 6'd0; cs_sel = 2'd0; cpol = 1'b0; cpha = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk_in);
      nbits = (i < 2) ? 6'd0 : 6'd33;
      if (i == 4) request = 1'b0;
      if (done === 1'b1) dones++;
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL badn_busy%0d got %b exp 0", i, busy); end
      checks++; if (spi_cen !== 4'hF) begin errors++; $display("FAIL badn_cen%0d got %b exp 1111", i, spi_cen); end
    end
    checks++; if (dones !== 0) begin errors++; $display("FAIL badn_done got %0d exp 0", dones); end
  endtask

  task automatic test_reset_mid;
    int dones = 0;
    @(negedge clk_in);
    request = 1'b1; nbits = 6'd16; cs_sel = 2'd0; cpol = 1'b0; cpha = 1'b0; mosi_data = 32'hBEEF;
    @(negedge clk_in); request = 1'b0;
    repeat (25) @(negedge clk_in);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL rmid_busy_before got %b exp 1", busy); end
    checks++; if (spi_scl !== 1'b0) begin errors++; $display("FAIL rmid_scl_before got %b exp 0", spi_scl); end
    nrst = 1'b0;
    #1;
    checks++; if (spi_cen !== 4'hF) begin errors++; $display("FAIL rmid_cen got %b exp 1111", spi_cen); end
    checks++; if (spi_scl !== 1'b1) begin errors++; $display("FAIL rmid_scl got %b exp 1", spi_scl); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rmid_busy got %b exp 0", busy); end
    checks++; if (miso_data !== 32'h0) begin errors++; $display("FAIL rmid_miso got %h exp 0", miso_data); end
    for (int i = 0; i < 8; i++) begin
      @(negedge clk_in);
      if (i == 3) nrst = 1'b1;
      if (done === 1'b1) dones++;
    end
    checks++; if (dones !== 0) begin errors++; $display("FAIL rmid_done got %0d exp 0", dones); end
    @(negedge clk_in); div_wr = 1'b1; div_val = 16'd0;
    @(negedge clk_in); div_wr = 1'b0;
    run_xfer(6'd8, 2'd0, 1'b0, 1'b0, 32'h3C, 1'b0, 1'b0, 16'd0, 100);
    checks++; if (res_miso !== 32'h3C) begin errors++; $display("FAIL rmid_next_miso got %h exp 3c", res_miso); end
    checks++; if (res_done_off !== 18) begin errors++; $display("FAIL rmid_next_done got %0d exp 18", res_done_off); end
  endtask

`ifdef SPI_3WIRE_EN
  task automatic test_3wire;
    slv_loop = 1'b0; slv_tx = 32'h003C; slv3_en = 1'b1; spi3w = 1'b1; nwr = 6'd8;
    run_xfer(6'd16, 2'd0, 1'b0, 1'b0, 32'h8100, 1'b0, 1'b0, 16'd0, 100);
    checks++; if (res_miso !== 32'h813C) begin errors++; $display("FAIL w3_miso got %h exp 813c", res_miso); end
    checks++; if (res_done_off !== 34) begin errors++; $display("FAIL w3_done got %0d exp 34", res_done_off); end
    spi3w = 1'b0; slv3_en = 1'b0; slv_loop = 1'b1;
  endtask
`endif

  initial begin
    nrst = 1'b0; div_wr = 1'b0; div_val = '0; request = 1'b0; nbits = '0; cs_sel = '0;
    cpol = 1'b0; cpha = 1'b0; mosi_data = '0;
`ifdef SPI_3WIRE_EN
    spi3w = 1'b0; nwr = '0;
`endif
    test_reset;
    test_div_reset;
    test_mode0;
    test_modes;
    test_div_write;
    test_back_to_back;
    test_bad_nbits;
    test_reset_mid;
`ifdef SPI_3WIRE_EN
    test_3wire;
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired checks %0d errors %0d", checks, errors);
    $fatal(1, "watchdog");
  end

endmodule
